// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM encodings and the round-robin pick for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_SIZE       = 31;
  localparam int INSTR_SIZE      = 31;
  localparam int MEM_ARB_TIMEOUT = 255;

  localparam logic [1:0] WSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } grant_e;

  // On a tie the requester that did not win last time gets the bus.
  function automatic grant_e pick_grant(input logic i_req, input logic d_req, input grant_e last);
    grant_e g;
    if (i_req && d_req) begin
      g = (last == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
    end else if (i_req) begin
      g = GNT_IMEM;
    end else begin
      g = GNT_DMEM;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// one outstanding transaction at a time, with a timeout abort when mem_ack never comes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = MEM_ARB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_SIZE:0]    imem_rd_addr,
  input  logic                  imem_rd_enable,
  output logic [INSTR_SIZE:0]   imem_rd_data,
  output logic                  imem_rd_ready,
  input  logic [ADDR_SIZE:0]    dmem_addr,
  input  logic                  dmem_r_enable,
  input  logic                  dmem_w_enable,
  input  logic [1:0]            dmem_w_size,
  input  logic [INSTR_SIZE:0]   dmem_w_data,
  output logic [INSTR_SIZE:0]   dmem_r_data,
  output logic                  dmem_ready,
  output logic [ADDR_SIZE:0]    mem_addr,
  output logic [INSTR_SIZE:0]   mem_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [1:0]            mem_wsize,
  input  logic [INSTR_SIZE:0]   mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t CNT_PRE = cnt_t'(TIMEOUT - 1);
  localparam cnt_t CNT_MAX = cnt_t'(TIMEOUT);

  arb_state_e           state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  cnt_t                 count_q, count_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [1:0]           mem_wsize_q, mem_wsize_d;
  logic [ADDR_SIZE:0]   mem_addr_q, mem_addr_d;
  logic [INSTR_SIZE:0]  mem_wdata_q, mem_wdata_d;
  logic [INSTR_SIZE:0]  hold_q, hold_d;
  logic                 imem_ready_q, imem_ready_d;
  logic                 dmem_ready_q, dmem_ready_d;
  logic                 bus_error_q, bus_error_d;
  logic                 imem_pend_s, dmem_pend_s;
  grant_e               gnt_s;

  // A requester in its own ready cycle still shows its old level request; mask it.
  assign imem_pend_s = imem_rd_enable && !imem_ready_q;
  assign dmem_pend_s = (dmem_r_enable || dmem_w_enable) && !dmem_ready_q;
  assign gnt_s       = pick_grant(imem_pend_s, dmem_pend_s, last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_wsize_d  = mem_wsize_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hold_d       = hold_q;
    imem_ready_d = 1'b0;
    dmem_ready_d = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (imem_pend_s || dmem_pend_s) begin
          last_grant_d = gnt_s;
          count_d      = CNT_ONE;
          mem_req_d    = 1'b1;
          if (gnt_s == GNT_IMEM) begin
            state_d     = GRANT_I;
            mem_addr_d  = imem_rd_addr;
            mem_we_d    = 1'b0;
            mem_wsize_d = WSIZE_WORD;
            mem_wdata_d = '0;
          end else begin
            state_d     = GRANT_D;
            mem_addr_d  = dmem_addr;
            mem_we_d    = dmem_w_enable;
            mem_wsize_d = dmem_w_size;
            mem_wdata_d = dmem_w_data;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        // bus_error is already visible in the final GRANT cycle; leave without a ready.
        if (count_q == CNT_MAX) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          count_d   = '0;
        end else if (mem_ack) begin
          hold_d    = mem_rdata;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          count_d   = '0;
          if (state_q == GRANT_I) begin
            imem_ready_d = 1'b1;
          end else begin
            dmem_ready_d = 1'b1;
          end
        end else begin
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_PRE) begin
            bus_error_d = 1'b1;
          end else begin
            bus_error_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        count_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DMEM;
      count_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wsize_q  <= 2'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hold_q       <= '0;
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_wsize_q  <= mem_wsize_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hold_q       <= hold_d;
      imem_ready_q <= imem_ready_d;
      dmem_ready_q <= dmem_ready_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign imem_rd_data  = hold_q;
  assign dmem_r_data   = hold_q;
  assign imem_rd_ready = imem_ready_q;
  assign dmem_ready    = dmem_ready_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_wsize     = mem_wsize_q;
  assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, tie/round-robin streams, timeout and reset abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rd_addr;
  logic        imem_rd_enable;
  logic [31:0] imem_rd_data;
  logic        imem_rd_ready;
  logic [31:0] dmem_addr;
  logic        dmem_r_enable;
  logic        dmem_w_enable;
  logic [1:0]  dmem_w_size;
  logic [31:0] dmem_w_data;
  logic [31:0] dmem_r_data;
  logic        dmem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_wsize;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .imem_rd_addr(imem_rd_addr), .imem_rd_enable(imem_rd_enable),
    .imem_rd_data(imem_rd_data), .imem_rd_ready(imem_rd_ready),
    .dmem_addr(dmem_addr), .dmem_r_enable(dmem_r_enable), .dmem_w_enable(dmem_w_enable),
    .dmem_w_size(dmem_w_size), .dmem_w_data(dmem_w_data),
    .dmem_r_data(dmem_r_data), .dmem_ready(dmem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wsize(mem_wsize), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_imem;
    logic [31:0] rd;

    reset = 1'b1; imem_rd_addr = '0; imem_rd_enable = 1'b0;
    dmem_addr = '0; dmem_r_enable = 1'b0; dmem_w_enable = 1'b0;
    dmem_w_size = 2'd0; dmem_w_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    do_reset();

    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst_iready", {31'd0, imem_rd_ready}, 32'd0);
    chk("rst_dready", {31'd0, dmem_ready}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wsize", {30'd0, mem_wsize}, 32'd0);
    chk("rst_hold", imem_rd_data, 32'd0);

    // Fetch from 0x100, ack on the third GRANT cycle.
    imem_rd_addr = 32'h0000_0100; imem_rd_enable = 1'b1;
    tick();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h0000_0100);
    chk("f_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    tick();
    chk("f_wait_iready", {31'd0, imem_rd_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 1'b0; imem_rd_enable = 1'b0;
    chk("f_iready", {31'd0, imem_rd_ready}, 32'd1);
    chk("f_idata", imem_rd_data, 32'h0050_0093);
    chk("f_req_low", {31'd0, mem_req}, 32'd0);
    tick();
    chk("f_iready_pulse", {31'd0, imem_rd_ready}, 32'd0);
    chk("f_idata_held", imem_rd_data, 32'h0050_0093);

    // Word store; the requester changes its data after grant, the bus must not.
    dmem_addr = 32'h0000_2004; dmem_w_enable = 1'b1; dmem_w_size = 2'd2;
    dmem_w_data = 32'hDEAD_BEEF;
    tick();
    chk("s_mem_req", {31'd0, mem_req}, 32'd1);
    chk("s_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_mem_wsize", {30'd0, mem_wsize}, 32'd2);
    chk("s_mem_addr", mem_addr, 32'h0000_2004);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    dmem_w_data = 32'h1234_5678;
    tick();
    chk("s_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0; dmem_w_enable = 1'b0;
    chk("s_dready", {31'd0, dmem_ready}, 32'd1);
    chk("s_no_iready", {31'd0, imem_rd_ready}, 32'd0);
    tick();
    chk("s_dready_pulse", {31'd0, dmem_ready}, 32'd0);

    // Tie after reset, then continuous fetch+load streams: I,D,I,D,I.
    do_reset();
    imem_rd_addr = 32'h0000_0010; imem_rd_enable = 1'b1;
    dmem_addr = 32'h0000_0020; dmem_r_enable = 1'b1; dmem_w_size = 2'd0;
    tick();
    exp_imem = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_addr%0d", i), mem_addr, exp_imem ? 32'h0000_0010 : 32'h0000_0020);
      chk($sformatf("rr_we%0d", i), {31'd0, mem_we}, 32'd0);
      rd = 32'hA000_0000 + i;
      mem_ack = 1'b1; mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
      chk($sformatf("rr_iready%0d", i), {31'd0, imem_rd_ready}, {31'd0, exp_imem});
      chk($sformatf("rr_dready%0d", i), {31'd0, dmem_ready}, {31'd0, ~exp_imem});
      chk($sformatf("rr_data%0d", i), exp_imem ? imem_rd_data : dmem_r_data, rd);
      if (i == 4) begin
        imem_rd_enable = 1'b0; dmem_r_enable = 1'b0;
      end
      tick();
      exp_imem = ~exp_imem;
    end
    chk("rr_idle_req", {31'd0, mem_req}, 32'd0);

    // Last grant was fetch, so a fresh tie goes to data.
    imem_rd_enable = 1'b1; dmem_r_enable = 1'b1;
    tick();
    chk("tie2_addr", mem_addr, 32'h0000_0020);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0; imem_rd_enable = 1'b0; dmem_r_enable = 1'b0;
    chk("tie2_dready", {31'd0, dmem_ready}, 32'd1);
    tick();
    chk("tie2_no_regrant", {31'd0, mem_req}, 32'd0);

    // Timeout: no ack, TIMEOUT=8.
    imem_rd_addr = 32'h0000_0300; imem_rd_enable = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("to_req_c%0d", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("to_berr_c%0d", k), {31'd0, bus_error}, 32'd0);
      tick();
    end
    imem_rd_enable = 1'b0;
    chk("to_berr_c8", {31'd0, bus_error}, 32'd1);
    chk("to_req_c8", {31'd0, mem_req}, 32'd1);
    tick();
    chk("to_req_after", {31'd0, mem_req}, 32'd0);
    chk("to_berr_pulse", {31'd0, bus_error}, 32'd0);
    chk("to_no_iready", {31'd0, imem_rd_ready}, 32'd0);
    tick();
    chk("to_no_iready2", {31'd0, imem_rd_ready}, 32'd0);

    // Reset while a load waits for ack; the late ack must be ignored.
    dmem_addr = 32'h0000_0440; dmem_r_enable = 1'b1;
    tick();
    chk("ra_req", {31'd0, mem_req}, 32'd1);
    chk("ra_addr", mem_addr, 32'h0000_0440);
    tick();
    reset = 1'b1; dmem_r_enable = 1'b0;
    tick();
    reset = 1'b0;
    chk("ra_req_low", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ack = 1'b0;
    chk("ra_late_dready", {31'd0, dmem_ready}, 32'd0);
    chk("ra_late_hold", dmem_r_data, 32'd0);
    chk("ra_late_req", {31'd0, mem_req}, 32'd0);
    imem_rd_addr = 32'h0000_0500; imem_rd_enable = 1'b1;
    dmem_addr = 32'h0000_0600; dmem_r_enable = 1'b1;
    tick();
    chk("ra_tie_fetch", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0777;
    tick();
    mem_ack = 1'b0; imem_rd_enable = 1'b0; dmem_r_enable = 1'b0;
    chk("ra_tie_iready", {31'd0, imem_rd_ready}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
